cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Exception/interrupt sequencer sitting directly upstream of the CP0 register block.
- Collects exception requests, ERET and hardware interrupts from the pipeline commit point.
- Computes the new EPC/Status/Cause/BadVAddr values and drives them, with their write strobes, into the CP0 register block.
- Then flushes the pipeline and redirects fetch to the handler vector or to EPC.

Parameters:
- VEC_BOOT_GEN, 32'hBFC00180, general vector when Status.BEV=1
- VEC_BOOT_REFILL, 32'hBFC00100, TLB-refill vector when BEV=1
- VEC_GEN, 32'h80000080, general vector when BEV=0
- VEC_REFILL, 32'h80000000, TLB-refill vector when BEV=0

Ports:
- clk  in  1  clock
- res  in  1  reset; synchronous, active-high
- exc_req  in  1  committing instruction raised an exception
- exc_code  in  5  ExcCode of the request
- exc_refill  in  1  TLB miss with no matching entry (use refill vector)
- exc_pc  in  32  PC of the faulting instruction
- exc_bd  in  1  faulting instruction is in a branch delay slot
- exc_badva  in  32  faulting virtual address
- exc_badva_valid  in  1  exc_badva is meaningful
- eret_req  in  1  ERET at commit
- commit_valid  in  1  a valid instruction is at commit (interrupt may be taken)
- commit_pc  in  32  PC at commit
- commit_bd  in  1  instruction at commit is in a delay slot
- hw_int  in  6  asynchronous hardware interrupt lines
- cp0_status, cp0_cause, cp0_epc  in  32 each  current CP0 register values
- out_epc, out_status, out_cause, out_badvaddr  out  32 each  values to write
- we_epc, we_status, we_cause, we_badvaddr  out  1 each  write strobes
- busy  out  1  sequencer active; pipeline must stall commit
- flush  out  1  kill all in-flight instructions
- redirect  out  1  fetch must load redirect_pc
- redirect_pc  out  32  new fetch PC
- int_pending  out  1  an enabled interrupt is pending

Behaviour:
- Reset (synchronous): all outputs 0, state IDLE, interrupt synchronisers cleared. Asserting res in any state aborts the sequence with no further writes.
- hw_int passes through a 2-flop synchroniser giving hw_sync. The IP vector is {hw_sync, cp0_cause[9:8]}.
- int_pending = cp0_status[0] (IEc) & |(IP & cp0_status[15:8]). It is registered, so it lags hw_int by 3 cycles.
- FSM states are IDLE, ENTER, ERET_W and REDIR.
- IDLE priority: exc_req > (int_pending & commit_valid) > eret_req.
  - exc_req: latch code, pc, bd, badva, badva_valid and refill; go to ENTER.
  - Interrupt: latch code 0, commit_pc, commit_bd, badva_valid=0, refill=0; go to ENTER.
  - eret_req: go to ERET_W.
- ENTER (1 cycle): we_epc=we_status=we_cause=1; we_badvaddr=badva_valid.
  - out_epc = bd ? pc-32'd4 : pc (mod 2^32).
  - out_status = {cp0_status[31:6], cp0_status[3:0], 2'b00}, i.e. push the KU/IE stack.
  - out_cause = {bd, cp0_cause[30:16], IP, cp0_cause[7], code, cp0_cause[1:0]}.
  - Next state REDIR.
- ERET_W (1 cycle): we_status=we_cause=1.
  - out_status = {cp0_status[31:6], cp0_status[5:4], cp0_status[5:2]}, i.e. pop the stack.
  - out_cause = cp0_cause, unchanged.
  - Latch cp0_epc as the target; next state REDIR.
- REDIR (1 cycle): flush=redirect=1, then IDLE.
  - After an exception: redirect_pc = BEV (cp0_status[22]) ? (refill ? VEC_BOOT_REFILL : VEC_BOOT_GEN) : (refill ? VEC_REFILL : VEC_GEN).
  - After ERET: redirect_pc = the latched EPC.
- Latency: request sampled at edge N, CP0 write strobes at N+1, redirect at N+2.
- busy is high in ENTER, ERET_W and REDIR. Requests arriving while busy are ignored; the pipeline is flushed and will re-raise them.
- Strobes are single-cycle pulses; all write/redirect outputs are 0 outside their states.
- Simultaneous exc_req and eret_req: the exception wins and ERET is dropped.
- A nested exception arriving in REDIR is ignored and re-raised after redirect.

Decomposition:
- Shared package/header holds the ExcCode constants (INT=0, MOD=1, TLBL=2, TLBS=3, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12), the Status/Cause bit-position defines (IEc=0, BEV=22, IM=15:8, BD=31, IP=15:8, CODE=6:2), the vector constants and the state encoding.
- One sub-module, cp0_int_sync: the 2-flop synchroniser plus the pending-interrupt logic.

Test Plan:
- Status=0x0000FF01, exc_req code 12, pc=0x80001000, bd=0:
  - at N+1: out_epc=0x80001000, out_cause[6:2]=12, out_status[5:0]=0x04, we_badvaddr=0;
  - at N+2: redirect_pc=0x80000080.
- exc_req code 2, refill=1, bd=1, pc=0x80002004, badva=0x00400000, Status.BEV=1:
  - out_epc=0x80002000, cause[31]=1, we_badvaddr=1, out_badvaddr=0x00400000;
  - redirect_pc=0xBFC00100.
- hw_int[0] raised, Status=0x00000401, commit_valid=1, commit_pc=0x80000500:
  - int_pending rises 3 cycles later;
  - then out_cause[10]=1, code 0, out_epc=0x80000500.
- ERET with Status[5:0]=0x0C, EPC=0x80000504:
  - out_status[5:0]=0x03, we_epc=0;
  - redirect_pc=0x80000504.
- exc_req and eret_req in the same cycle -> exception sequence only. A second exc_req during busy -> no extra strobes.
- res asserted during ENTER -> next cycle all outputs 0, state IDLE, no redirect.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants for the CP0 exception sequencer: ExcCodes, Status/Cause
// bit positions, handler vectors and the sequencer state encoding.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IEC   = 0;
  localparam int STATUS_BEV   = 22;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_CODE_LO = 2;
  localparam int CAUSE_CODE_HI = 6;

  localparam logic [31:0] VEC_BOOT_GEN_DEF    = 32'hBFC00180;
  localparam logic [31:0] VEC_BOOT_REFILL_DEF = 32'hBFC00100;
  localparam logic [31:0] VEC_GEN_DEF         = 32'h80000080;
  localparam logic [31:0] VEC_REFILL_DEF      = 32'h80000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_ERET_W = 2'd2,
    ST_REDIR  = 2'd3
  } state_e;

endpackage

// File: rtl/cp0_int_sync.sv
// Hardware interrupt synchroniser and registered pending-interrupt flag.
module cp0_int_sync
  import cp0_exc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic [5:0] hw_int,
  input  logic       ie,
  input  logic [7:0] im,
  input  logic [1:0] ip_sw,
  output logic [7:0] ip,
  output logic       int_pending
);

  logic [5:0] meta_q, meta_d;
  logic [5:0] sync_q, sync_d;
  logic       pend_q, pend_d;

  always_comb begin
    meta_d = hw_int;
    sync_d = meta_q;
    ip     = {sync_q, ip_sw};
    pend_d = ie & (|(ip & im));
  end

  always_ff @(posedge clk) begin
    if (res) begin
      meta_q <= '0;
      sync_q <= '0;
      pend_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      pend_q <= pend_d;
    end
  end

  assign int_pending = pend_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt/ERET sequencer: computes CP0 write-back values,
// then flushes the pipeline and redirects fetch.
//
// state    | meaning
// IDLE     | waiting for exception, interrupt or ERET at commit
// ENTER    | write EPC/Status/Cause (and BadVAddr) for exception entry
// ERET_W   | pop Status stack, capture EPC as return target
// REDIR    | flush pipeline, redirect fetch to vector or EPC
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BOOT_GEN    = VEC_BOOT_GEN_DEF,
  parameter logic [31:0] VEC_BOOT_REFILL = VEC_BOOT_REFILL_DEF,
  parameter logic [31:0] VEC_GEN         = VEC_GEN_DEF,
  parameter logic [31:0] VEC_REFILL      = VEC_REFILL_DEF
) (
  input  logic        clk,
  input  logic        res,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        exc_refill,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badva,
  input  logic        exc_badva_valid,
  input  logic        eret_req,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic [5:0]  hw_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic [31:0] out_epc,
  output logic [31:0] out_status,
  output logic [31:0] out_cause,
  output logic [31:0] out_badvaddr,
  output logic        we_epc,
  output logic        we_status,
  output logic        we_cause,
  output logic        we_badvaddr,
  output logic        busy,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        int_pending
);

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [31:0] badva_q, badva_d;
  logic        bv_q, bv_d;
  logic        refill_q, refill_d;
  logic        eret_q, eret_d;
  logic [7:0]  ip;

  cp0_int_sync u_int_sync (
    .clk         (clk),
    .res         (res),
    .hw_int      (hw_int),
    .ie          (cp0_status[STATUS_IEC]),
    .im          (cp0_status[STATUS_IM_HI:STATUS_IM_LO]),
    .ip_sw       (cp0_cause[CAUSE_IP_LO+1:CAUSE_IP_LO]),
    .ip          (ip),
    .int_pending (int_pending)
  );

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    pc_d         = pc_q;
    bd_d         = bd_q;
    badva_d      = badva_q;
    bv_d         = bv_q;
    refill_d     = refill_q;
    eret_d       = eret_q;
    out_epc      = '0;
    out_status   = '0;
    out_cause    = '0;
    out_badvaddr = '0;
    we_epc       = 1'b0;
    we_status    = 1'b0;
    we_cause     = 1'b0;
    we_badvaddr  = 1'b0;
    busy         = 1'b0;
    flush        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;

    case (state_q)
      ST_IDLE: begin
        // exception beats interrupt beats ERET; a dropped ERET is re-raised after the flush
        if (exc_req) begin
          code_d   = exc_code;
          pc_d     = exc_pc;
          bd_d     = exc_bd;
          badva_d  = exc_badva;
          bv_d     = exc_badva_valid;
          refill_d = exc_refill;
          eret_d   = 1'b0;
          state_d  = ST_ENTER;
        end else if (int_pending && commit_valid) begin
          code_d   = EXC_INT;
          pc_d     = commit_pc;
          bd_d     = commit_bd;
          badva_d  = '0;
          bv_d     = 1'b0;
          refill_d = 1'b0;
          eret_d   = 1'b0;
          state_d  = ST_ENTER;
        end else if (eret_req) begin
          eret_d  = 1'b1;
          state_d = ST_ERET_W;
        end
      end

      ST_ENTER: begin
        busy         = 1'b1;
        we_epc       = 1'b1;
        we_status    = 1'b1;
        we_cause     = 1'b1;
        we_badvaddr  = bv_q;
        out_epc      = bd_q ? (pc_q - 32'd4) : pc_q;
        out_status   = {cp0_status[31:6], cp0_status[3:0], 2'b00};
        out_cause    = {bd_q, cp0_cause[30:16], ip, cp0_cause[7], code_q, cp0_cause[1:0]};
        out_badvaddr = bv_q ? badva_q : '0;
        state_d      = ST_REDIR;
      end

      ST_ERET_W: begin
        busy       = 1'b1;
        we_status  = 1'b1;
        we_cause   = 1'b1;
        out_status = {cp0_status[31:6], cp0_status[5:4], cp0_status[5:2]};
        out_cause  = cp0_cause;
        pc_d       = cp0_epc;
        state_d    = ST_REDIR;
      end

      ST_REDIR: begin
        busy     = 1'b1;
        flush    = 1'b1;
        redirect = 1'b1;
        if (eret_q)
          redirect_pc = pc_q;
        else if (cp0_status[STATUS_BEV])
          redirect_pc = refill_q ? VEC_BOOT_REFILL : VEC_BOOT_GEN;
        else
          redirect_pc = refill_q ? VEC_REFILL : VEC_GEN;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      pc_q     <= '0;
      bd_q     <= 1'b0;
      badva_q  <= '0;
      bv_q     <= 1'b0;
      refill_q <= 1'b0;
      eret_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      pc_q     <= pc_d;
      bd_q     <= bd_d;
      badva_q  <= badva_d;
      bv_q     <= bv_d;
      refill_q <= refill_d;
      eret_q   <= eret_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: stimulus pushes expected CP0 writes and
// redirects, a negedge monitor pops and compares whenever the DUT drives them.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic        exc_req, exc_refill, exc_bd, exc_badva_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badva;
  logic        eret_req, commit_valid, commit_bd;
  logic [31:0] commit_pc;
  logic [5:0]  hw_int;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic [31:0] out_epc, out_status, out_cause, out_badvaddr;
  logic        we_epc, we_status, we_cause, we_badvaddr;
  logic        busy, flush, redirect, int_pending;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          redir;
    logic [3:0]  we;      // {badvaddr, cause, status, epc}
    logic [31:0] epc;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] badva;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cp0_exc_ctrl dut (
    .clk(clk), .res(res),
    .exc_req(exc_req), .exc_code(exc_code), .exc_refill(exc_refill),
    .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badva(exc_badva),
    .exc_badva_valid(exc_badva_valid), .eret_req(eret_req),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_bd(commit_bd),
    .hw_int(hw_int), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .cp0_epc(cp0_epc),
    .out_epc(out_epc), .out_status(out_status), .out_cause(out_cause),
    .out_badvaddr(out_badvaddr),
    .we_epc(we_epc), .we_status(we_status), .we_cause(we_cause),
    .we_badvaddr(we_badvaddr),
    .busy(busy), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_write(input logic [3:0] we, input logic [31:0] epc, input logic [31:0] st,
                            input logic [31:0] ca, input logic [31:0] bva);
    exp_t e;
    e.redir = 1'b0; e.we = we; e.epc = epc; e.status = st; e.cause = ca; e.badva = bva; e.rpc = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_redir(input logic [31:0] rpc);
    exp_t e;
    e.redir = 1'b1; e.we = '0; e.epc = '0; e.status = '0; e.cause = '0; e.badva = '0; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  task automatic do_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                        input logic [31:0] badva, input logic bv, input logic refill);
    @(posedge clk); #1;
    exc_req = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
    exc_badva = badva; exc_badva_valid = bv; exc_refill = refill;
    @(posedge clk); #1;
    exc_req = 1'b0; exc_badva_valid = 1'b0; exc_refill = 1'b0; exc_bd = 1'b0;
  endtask

  always @(negedge clk) begin
    if (we_epc || we_status || we_cause || we_badvaddr) begin
      if (exp_q.size() == 0 || exp_q[0].redir) begin
        chk("unexpected_write", {28'd0, we_badvaddr, we_cause, we_status, we_epc}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("we", {28'd0, we_badvaddr, we_cause, we_status, we_epc}, {28'd0, mon_e.we});
        chk("out_epc", out_epc, mon_e.epc);
        chk("out_status", out_status, mon_e.status);
        chk("out_cause", out_cause, mon_e.cause);
        chk("out_badvaddr", out_badvaddr, mon_e.badva);
        chk("write_no_redirect", {30'd0, flush, redirect}, 32'd0);
      end
    end
    if (redirect) begin
      if (exp_q.size() == 0 || !exp_q[0].redir) begin
        chk("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("redirect_pc", redirect_pc, mon_e.rpc);
        chk("redirect_flush_busy", {30'd0, flush, busy}, 32'd3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res = 1'b1;
    exc_req = 1'b0; exc_code = '0; exc_refill = 1'b0; exc_pc = '0; exc_bd = 1'b0;
    exc_badva = '0; exc_badva_valid = 1'b0; eret_req = 1'b0;
    commit_valid = 1'b0; commit_pc = '0; commit_bd = 1'b0; hw_int = '0;
    cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {23'd0, busy, flush, redirect, we_epc, we_status, we_cause, we_badvaddr, int_pending}, 32'd0);
    chk("reset_vals", out_epc | out_status | out_cause | out_badvaddr | redirect_pc, 32'd0);
    res = 1'b0;

    // overflow, BEV=0, no delay slot
    cp0_status = 32'h0000FF01; cp0_cause = 32'h0;
    push_write(4'b0111, 32'h80001000, 32'h0000FF04, 32'h00000030, 32'h0);
    push_redir(32'h80000080);
    do_exc(5'd12, 32'h80001000, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    repeat (4) @(posedge clk);

    // TLB refill in delay slot, BEV=1
    cp0_status = 32'h00400001;
    push_write(4'b1111, 32'h80002000, 32'h00400004, 32'h80000008, 32'h00400000);
    push_redir(32'hBFC00100);
    do_exc(5'd2, 32'h80002004, 1'b1, 32'h00400000, 1'b1, 1'b1);
    repeat (4) @(posedge clk);

    // hardware interrupt 0 through the synchroniser
    cp0_status = 32'h00000401; cp0_cause = 32'h0;
    @(posedge clk); #1;
    hw_int = 6'b000001;
    @(posedge clk);
    @(posedge clk); #1;
    chk("int_pending_early", {31'd0, int_pending}, 32'd0);
    @(posedge clk); #1;
    chk("int_pending_lag3", {31'd0, int_pending}, 32'd1);
    push_write(4'b0111, 32'h80000500, 32'h00000404, 32'h00000400, 32'h0);
    push_redir(32'h80000080);
    commit_valid = 1'b1; commit_pc = 32'h80000500; commit_bd = 1'b0;
    @(posedge clk); #1;
    commit_valid = 1'b0; hw_int = '0;
    repeat (6) @(posedge clk);

    // ERET pops the KU/IE stack and returns to EPC
    cp0_status = 32'h0000000C; cp0_cause = 32'h00000300; cp0_epc = 32'h80000504;
    push_write(4'b0110, 32'h0, 32'h00000003, 32'h00000300, 32'h0);
    push_redir(32'h80000504);
    @(posedge clk); #1;
    eret_req = 1'b1;
    @(posedge clk); #1;
    eret_req = 1'b0;
    repeat (4) @(posedge clk);

    // simultaneous exc+eret, then a held exc_req while busy is ignored
    cp0_status = 32'h0000FF01; cp0_cause = 32'h0;
    push_write(4'b0111, 32'h80003000, 32'h0000FF04, 32'h00000020, 32'h0);
    push_redir(32'h80000080);
    @(posedge clk); #1;
    exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h80003000; exc_bd = 1'b0; eret_req = 1'b1;
    @(posedge clk); #1;
    eret_req = 1'b0; exc_code = 5'd9; exc_pc = 32'h80009000;
    @(negedge clk);
    chk("busy_enter", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    exc_req = 1'b0;
    repeat (4) @(posedge clk);

    // reset during ENTER aborts before the redirect
    push_write(4'b0111, 32'h80003FFC, 32'h0000FF04, 32'h80000028, 32'h0);
    @(posedge clk); #1;
    exc_req = 1'b1; exc_code = 5'd10; exc_pc = 32'h80004000; exc_bd = 1'b1;
    @(posedge clk); #1;
    exc_req = 1'b0; exc_bd = 1'b0; res = 1'b1;
    @(posedge clk); #1;
    chk("abort_ctrl", {24'd0, busy, flush, redirect, we_epc, we_status, we_cause, we_badvaddr, int_pending}, 32'd0);
    chk("abort_vals", out_epc | out_status | out_cause | out_badvaddr | redirect_pc, 32'd0);
    res = 1'b0;
    repeat (4) @(posedge clk);

    // EPC wraps for a delay-slot fault at PC 0; BEV general vector
    cp0_status = 32'h00400000;
    push_write(4'b1111, 32'hFFFFFFFC, 32'h00400000, 32'h80000010, 32'h00000001);
    push_redir(32'hBFC00180);
    do_exc(5'd4, 32'h00000000, 1'b1, 32'h00000001, 1'b1, 1'b0);
    repeat (4) @(posedge clk);

    // refill with BEV=0
    cp0_status = 32'h00000000;
    push_write(4'b1111, 32'h80005000, 32'h00000000, 32'h0000000C, 32'h7FFFF000);
    push_redir(32'h80000000);
    do_exc(5'd3, 32'h80005000, 1'b0, 32'h7FFFF000, 1'b1, 1'b1);
    repeat (5) @(posedge clk);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
